// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and access-decoding helpers for the memory port arbiter
package Common;

  typedef logic [31:0] uint32_t;

  // {we, funct3} so loads and stores of the same width stay distinct
  typedef enum logic [3:0] {
    LB  = 4'h0,
    LH  = 4'h1,
    LW  = 4'h2,
    LBU = 4'h4,
    LHU = 4'h5,
    SB  = 4'h8,
    SH  = 4'h9,
    SW  = 4'hA
  } width_e;

  typedef enum logic {IDLE, RESP} state_e;

  function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] a);
    return funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
           (funct3[1:0] == 2'b01 && a[0]) || (funct3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] a);
    return funct3[1:0] == 2'b00 ? 4'b0001 << a : funct3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_align.sv
// load_align: picks the addressed lane of a memory word and sign/zero-extends it
module load_align
  import Common::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] funct3,
  input  uint32_t    word,
  output uint32_t    data
);

  width_e      code;
  logic [7:0]  b;
  logic [15:0] h;

  assign code = width_e'({1'b0, funct3});
  assign b    = word[{addr, 3'b000} +: 8];
  assign h    = addr[1] ? word[31:16] : word[15:0];

  // lane extension selected by the width code
  always_comb
    data = code == LB  ? {{24{b[7]}}, b} :
           code == LH  ? {{16{h[15]}}, h} :
           code == LW  ? word :
           code == LBU ? {24'b0, b} :
           code == LHU ? {16'b0, h} : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory between fetch and load/store with starvation guard
module mem_port_arbiter
  import Common::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output uint32_t     if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output uint32_t     ls_rdata,
  output logic        ls_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [3:0]  mem_maskByte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q;
  state_e        state_q, state_d;
  logic          resp_if_q, err_q, ls_fault, if_addr_unused;
  uint32_t       load_data;

  assign if_addr_unused = ^if_addr[1:0];
  assign ls_fault       = access_fault(ls_funct3, ls_addr[1:0]);
  assign if_gnt         = rst && if_req && (!ls_req || starve_q == CW'(STARVE_LIMIT));
  assign ls_gnt         = rst && ls_req && !if_gnt;
  assign mem_read       = if_gnt || (ls_gnt && !ls_we && !ls_fault);
  assign mem_write      = ls_gnt && ls_we && !ls_fault;
  assign mem_address    = if_gnt ? if_addr[31:2] : ls_gnt ? ls_addr[31:2] : '0;
  assign mem_maskByte   = mem_write ? byte_mask(ls_funct3, ls_addr[1:0]) : '0;
  assign mem_wdata      = ls_wdata;
  assign if_rvalid      = state_q == RESP && resp_if_q;
  assign ls_rvalid      = state_q == RESP && !resp_if_q;
  assign ls_err         = ls_rvalid && err_q;

  load_align u_load_align (
    .addr  (ls_addr[1:0]),
    .funct3(ls_funct3),
    .word  (mem_rdata),
    .data  (load_data)
  );

  // a response is pending in the cycle after any grant
  always_comb state_d = (if_gnt || ls_gnt) ? RESP : IDLE;

  // response state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  // response data, fault flag and fetch starvation counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      starve_q  <= '0;
      resp_if_q <= 1'b0;
      err_q     <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      resp_if_q <= if_gnt;
      err_q     <= ls_gnt && ls_fault;
      if (if_gnt) if_rdata <= mem_rdata;
      if (ls_gnt) ls_rdata <= (ls_we || ls_fault) ? '0 : load_data;
      starve_q  <= if_gnt ? '0 :
                   (if_req && ls_gnt && starve_q != CW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the arbiter against a behavioural model
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 0, rst = 0;
  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [2:0]  ls_funct3 = 0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_read, mem_write;
  logic [31:0] if_rdata, ls_rdata, mem_wdata;
  logic [29:0] mem_address;
  logic [3:0]  mem_maskByte;

  int checks = 0, errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_maskByte(mem_maskByte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_fault(input logic [2:0] f3, input logic [1:0] a2);
    int f = int'(f3), a = int'(a2);
    return f == 3 || f == 6 || f == 7 || (f % 4 == 1 && a % 2 == 1) || (f % 4 == 2 && a != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a2, input logic [31:0] w);
    logic [31:0] sh, b, h;
    sh = w >> (8 * int'(a2));
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (int'(f3))
      0: return b >= 128 ? b - 256 : b;
      1: return h >= 32768 ? h - 65536 : h;
      2: return w;
      4: return b;
      5: return h;
      default: return 0;
    endcase
  endfunction

  // model state: starvation count and the response the DUT owes this cycle
  int          cnt = 0;
  bit          m_if_rv = 0, m_ls_rv = 0, m_err = 0;
  logic [31:0] m_if_rd = 0, m_ls_rd = 0;
  bit          s_gi = 0, s_gl = 0, s_flt = 0, s_if_req = 0;
  logic [31:0] s_if_next = 0, s_ls_next = 0;
  bit          e_gi, e_gl, e_flt, e_wr, e_rd;
  logic [3:0]  e_mk;
  int          e_sz, e_a;

  always @(negedge clk) begin
    e_flt = is_fault(ls_funct3, ls_addr[1:0]);
    e_gi  = rst && if_req && (!ls_req || cnt == LIM);
    e_gl  = rst && ls_req && !e_gi;
    e_wr  = e_gl && ls_we && !e_flt;
    e_rd  = e_gi || (e_gl && !ls_we && !e_flt);
    e_sz  = int'(ls_funct3) % 4;
    e_a   = int'(ls_addr[1:0]);
    e_mk  = !e_wr ? 4'd0 : e_sz == 0 ? 4'(1 << e_a) : e_sz == 1 ? 4'(3 << e_a) : 4'hF;
    chk("if_gnt", if_gnt, e_gi);
    chk("ls_gnt", ls_gnt, e_gl);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_maskByte", mem_maskByte, e_mk);
    if (e_gi || e_gl) chk("mem_address", mem_address, e_gi ? if_addr / 4 : ls_addr / 4);
    if (e_wr) chk("mem_wdata", mem_wdata, ls_wdata);
    chk("if_rvalid", if_rvalid, rst && m_if_rv);
    chk("ls_rvalid", ls_rvalid, rst && m_ls_rv);
    chk("ls_err", ls_err, rst && m_ls_rv && m_err);
    chk("if_rdata", if_rdata, rst ? m_if_rd : 0);
    chk("ls_rdata", ls_rdata, rst ? m_ls_rd : 0);
    s_gi      = e_gi;
    s_gl      = e_gl;
    s_flt     = e_flt;
    s_if_req  = if_req;
    s_if_next = mem_rdata;
    s_ls_next = (ls_we || e_flt) ? 0 : load_val(ls_funct3, ls_addr[1:0], mem_rdata);
  end

  always @(posedge clk)
    if (!rst) begin
      cnt     <= 0;
      m_if_rv <= 0;
      m_ls_rv <= 0;
      m_err   <= 0;
      m_if_rd <= 0;
      m_ls_rd <= 0;
    end else begin
      m_if_rv <= s_gi;
      m_ls_rv <= s_gl;
      m_err   <= s_gl && s_flt;
      if (s_gi) m_if_rd <= s_if_next;
      if (s_gl) m_ls_rd <= s_ls_next;
      cnt <= s_gi ? 0 : (s_if_req && s_gl && cnt < LIM) ? cnt + 1 : cnt;
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0;
    ls_req = 0;
    ls_we  = 0;
  endtask

  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    ls_req = 1;
    ls_we = we;
    ls_funct3 = f3;
    ls_addr = a;
    ls_wdata = wd;
  endtask

  initial begin
    ls_req = 1;
    if_req = 1;
    @(negedge clk);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_ls_rvalid", ls_rvalid, 0);
    cyc();
    idle();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if_req = 1;
      if_addr = 32'h200;
      ls_op(0, 3'b010, 32'h100, 0);
      @(negedge clk);
      chk("starve_ls_gnt", ls_gnt, i != 4);
      chk("starve_if_gnt", if_gnt, i == 4);
    end
    cyc();
    idle();
    cyc();
    ls_op(1, 3'b000, 32'h103, 32'hAB);
    @(negedge clk);
    chk("sb_mask", mem_maskByte, 4'b1000);
    chk("sb_addr", mem_address, 30'h40);
    chk("sb_wdata", mem_wdata, 32'hAB);
    cyc();
    idle();
    @(negedge clk);
    chk("sb_rvalid", ls_rvalid, 1);
    chk("sb_rdata", ls_rdata, 0);
    cyc();
    mem_rdata = 32'h0080FF00;
    ls_op(0, 3'b000, 32'h102, 0);
    cyc();
    ls_op(0, 3'b100, 32'h102, 0);
    @(negedge clk);
    chk("lb_rdata", ls_rdata, 32'hFFFFFF80);
    cyc();
    idle();
    @(negedge clk);
    chk("lbu_rdata", ls_rdata, 32'h00000080);
    cyc();
    ls_op(1, 3'b010, 32'h102, 32'h55);
    @(negedge clk);
    chk("sw_mis_gnt", ls_gnt, 1);
    chk("sw_mis_write", mem_write, 0);
    cyc();
    ls_op(0, 3'b011, 32'h100, 0);
    @(negedge clk);
    chk("sw_mis_err", ls_err, 1);
    chk("f3_011_read", mem_read, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("f3_011_err", ls_err, 1);
    chk("f3_011_rdata", ls_rdata, 0);
    cyc();
    mem_rdata = 32'h12345678;
    if_req = 1;
    if_addr = 32'h7;
    @(negedge clk);
    chk("fetch_addr", mem_address, 30'h1);
    cyc();
    idle();
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if_req = 1;
      ls_op(0, 3'b010, 32'h100, 0);
    end
    cyc();
    idle();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_rvalid", ls_rvalid, 0);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("post_rst_ls_rvalid", ls_rvalid, 0);
    chk("post_rst_if_rvalid", if_rvalid, 0);
    cyc();
    if_req = 1;
    ls_op(0, 3'b010, 32'h100, 0);
    @(negedge clk);
    chk("post_rst_cnt_ls", ls_gnt, 1);
    chk("post_rst_cnt_if", if_gnt, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = $urandom_range(0, 99) != 0;
      if_req = $urandom_range(0, 9) < 7;
      ls_req = $urandom_range(0, 9) < 7;
      ls_we = $urandom_range(0, 1) == 1;
      ls_funct3 = 3'($urandom);
      if (ls_we && (ls_funct3 == 3'd4 || ls_funct3 == 3'd5)) ls_funct3 = ls_funct3 - 3'd4;
      if_addr = $urandom;
      ls_addr = $urandom;
      ls_wdata = $urandom;
      mem_rdata = $urandom;
    end
    cyc();
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive fetch denials before fetch is forced to win.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports if_req in 1, if_addr in 32: instruction-fetch request and byte address.
REQ-005 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch grant, response strobe and response data.
REQ-006 SHALL have ports ls_req in 1, ls_we in 1, ls_funct3 in 3, ls_addr in 32, ls_wdata in 32: load/store request, write flag, RV32 width code, byte address, store data.
REQ-007 SHALL have ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out 32, ls_err out 1: load/store grant, response strobe, extended load data, fault flag.
REQ-008 SHALL have memory-side ports mem_read out 1, mem_write out 1, mem_address out 30 (word index), mem_maskByte out 4, mem_wdata out 32, mem_rdata in 32 (combinational read data).

Function
REQ-009 SHALL grant at most one requester per cycle; the grant is combinational in the cycle the request is presented, and the memory is driven in that same cycle.
REQ-010 SHALL give ls priority over if unless the starvation counter equals STARVE_LIMIT, in which case if wins.
REQ-011 Starvation counter SHALL increment on each cycle where if_req=1 and ls wins, reset to 0 on any if grant, and saturate at STARVE_LIMIT.
REQ-012 SHALL drive mem_address=addr[31:2] of the granted requester; mem_read=1 for a fetch or a load; mem_write=1 only for a granted, non-faulting store.
REQ-013 mem_maskByte SHALL be 4'b0001<<addr[1:0] for SB, 4'b0011<<addr[1:0] for SH, 4'b1111 for SW, and 0 when not writing.
REQ-014 mem_wdata SHALL equal ls_wdata unshifted; the store byte or half is carried in the low bits.
REQ-015 Fault conditions: half access with addr[0]=1; word access with addr[1:0]!=0; funct3 in {011,110,111}.
REQ-016 A faulting request SHALL still be granted, SHALL NOT assert mem_read or mem_write, and SHALL return ls_err=1 with ls_rdata=0.
REQ-017 Responses SHALL be registered: rvalid rises exactly 1 cycle after the grant for one cycle, and rdata is held until the next response.
REQ-018 Load data SHALL select the lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; a store response returns rvalid=1, rdata=0, err=0.
REQ-019 Back-to-back grants SHALL be permitted, giving one access per cycle with no bubble.
REQ-020 The FSM SHALL have 2 states: IDLE (no response pending) and RESP (response valid this cycle); IDLE->RESP on any grant; RESP->RESP on a new grant; RESP->IDLE otherwise.
REQ-021 The fetch path SHALL ignore if_addr[1:0] and return the full word.

Reset
REQ-022 While rst=0, the block SHALL hold if_rvalid, ls_rvalid, ls_err, gnt, mem_read, mem_write, and mem_maskByte at 0, rdata registers at 0, the starvation counter at 0, and the FSM in IDLE.
REQ-023 Reset asserted mid-access SHALL discard the pending response; no rvalid SHALL appear after release for a pre-reset grant.

Structure
REQ-024 The width-code enum (LB, LH, LW, LBU, LHU, SB, SH, SW) and uint32_t SHALL live in package Common.
REQ-025 Lane extraction and extension SHALL be one sub-module, load_align (addr[1:0], funct3, word in -> 32-bit out).

Verification
REQ-026 if_req=1 and ls_req=1 for 6 cycles with STARVE_LIMIT=4 -> ls granted cycles 0-3, if granted cycle 4, ls granted cycle 5.
REQ-027 SB at addr 0x103, wdata 0xAB -> mem_maskByte=4'b1000, mem_address=0x40, ls_rvalid next cycle with rdata 0.
REQ-028 LB at addr 0x102 with mem_rdata 0x0080FF00 -> ls_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-029 SW at addr 0x102 -> mem_write=0, ls_err=1 next cycle; funct3=3'b011 -> ls_err=1.
REQ-030 Fetch at if_addr 0x7 with mem_rdata 0x12345678 -> mem_address=1, if_rdata=0x12345678 one cycle later.
REQ-031 Grant in cycle N then rst=0 in cycle N+1 -> no rvalid after release, and the starvation counter reads 0.
